// File: rtl/id_ex_stage.sv
// D->E pipeline register for the 5-stage MIPS core, with combinational M/W
// forwarding into the E-stage operands that feed the ALU.
module id_ex_stage #(
    parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ir_d,
    input  logic [31:0] pc8_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic [4:0]  a3_m,
    input  logic        we_m,
    input  logic [31:0] wd_m,
    input  logic [4:0]  a3_w,
    input  logic        we_w,
    input  logic [31:0] wd_w,
    output logic [31:0] ir_e,
    output logic [31:0] pc8_e,
    output logic [31:0] numa,
    output logic [31:0] numb,
    output logic [31:0] rt_fwd_e
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    logic signed [31:0] rs_val;
    logic signed [31:0] rt_val;
    logic signed [31:0] imm_e;
    logic signed [31:0] rs_fwd;

    // ori/lui take the immediate as an unsigned field; everything else sign-extends.
    function automatic logic signed [31:0] ext_imm(input logic [31:0] ir);
        logic signed [15:0] imm16;
        imm16 = ir[15:0];
        if (ir[31:26] == OP_ORI || ir[31:26] == OP_LUI)
            return {16'h0000, ir[15:0]};
        else
            return 32'(imm16);
    endfunction

    // M wins over W because it holds the younger result; $0 is hardwired to zero.
    function automatic logic signed [31:0] fwd(
        input logic [4:0]         rsel,
        input logic signed [31:0] val,
        input logic [4:0]         m_a3,
        input logic               m_we,
        input logic [31:0]        m_wd,
        input logic [4:0]         w_a3,
        input logic               w_we,
        input logic [31:0]        w_wd
    );
        if (rsel == 5'd0)
            return '0;
        else if (m_we && m_a3 == rsel)
            return m_wd;
        else if (w_we && w_a3 == rsel)
            return w_wd;
        else
            return val;
    endfunction

    // D -> E register boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_e   <= '0;
            pc8_e  <= RESET_PC8;
            rs_val <= '0;
            rt_val <= '0;
            imm_e  <= '0;
        end else if (stall || flush) begin
            ir_e   <= '0;
            pc8_e  <= RESET_PC8;
            rs_val <= '0;
            rt_val <= '0;
            imm_e  <= '0;
        end else begin
            ir_e   <= ir_d;
            pc8_e  <= pc8_d;
            rs_val <= rd1_d;
            rt_val <= rd2_d;
            imm_e  <= ext_imm(ir_d);
        end
    end

    // E-stage operand selection
    assign rs_fwd   = fwd(ir_e[25:21], rs_val, a3_m, we_m, wd_m, a3_w, we_w, wd_w);
    assign rt_fwd_e = fwd(ir_e[20:16], rt_val, a3_m, we_m, wd_m, a3_w, we_w, wd_w);
    assign numa     = rs_fwd;
    assign numb     = (ir_e[31:26] == OP_RTYPE) ? rt_fwd_e : imm_e;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of D/M/W stimulus with hand-derived E-stage
// results, plus reset and mid-cycle reset sequences.
module tb_id_ex_stage;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [31:0] ir_d;
    logic [31:0] pc8_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [4:0]  a3_m;
    logic        we_m;
    logic [31:0] wd_m;
    logic [4:0]  a3_w;
    logic        we_w;
    logic [31:0] wd_w;
    logic [31:0] ir_e;
    logic [31:0] pc8_e;
    logic [31:0] numa;
    logic [31:0] numb;
    logic [31:0] rt_fwd_e;

    id_ex_stage #(.RESET_PC8(32'h0000_3008)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .ir_d(ir_d), .pc8_d(pc8_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .a3_m(a3_m), .we_m(we_m), .wd_m(wd_m),
        .a3_w(a3_w), .we_w(we_w), .wd_w(wd_w),
        .ir_e(ir_e), .pc8_e(pc8_e), .numa(numa), .numb(numb), .rt_fwd_e(rt_fwd_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc8;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  a3m;
        logic        wem;
        logic [31:0] wdm;
        logic [4:0]  a3w;
        logic        wew;
        logic [31:0] wdw;
        logic        stl;
        logic        fls;
        logic [31:0] e_ir;
        logic [31:0] e_pc8;
        logic [31:0] e_numa;
        logic [31:0] e_numb;
        logic [31:0] e_rt;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc8;
        logic [31:0] na;
        logic [31:0] nb;
        logic [31:0] rt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;

    function automatic vec_t mkv(
        input logic [31:0] ir, input logic [31:0] pc8,
        input logic [31:0] rd1, input logic [31:0] rd2,
        input logic [4:0] a3m, input logic wem, input logic [31:0] wdm,
        input logic [4:0] a3w, input logic wew, input logic [31:0] wdw,
        input logic stl, input logic fls,
        input logic [31:0] e_ir, input logic [31:0] e_pc8,
        input logic [31:0] e_numa, input logic [31:0] e_numb, input logic [31:0] e_rt
    );
        vec_t v;
        v.ir = ir; v.pc8 = pc8; v.rd1 = rd1; v.rd2 = rd2;
        v.a3m = a3m; v.wem = wem; v.wdm = wdm;
        v.a3w = a3w; v.wew = wew; v.wdw = wdw;
        v.stl = stl; v.fls = fls;
        v.e_ir = e_ir; v.e_pc8 = e_pc8; v.e_numa = e_numa; v.e_numb = e_numb; v.e_rt = e_rt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got ir_e=%08h expected an entry", tag, ir_e);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".ir_e"},     ir_e,     e.ir);
        check({tag, ".pc8_e"},    pc8_e,    e.pc8);
        check({tag, ".numa"},     numa,     e.na);
        check({tag, ".numb"},     numb,     e.nb);
        check({tag, ".rt_fwd_e"}, rt_fwd_e, e.rt);
    endtask

    task automatic drive(input vec_t v);
        ir_d = v.ir; pc8_d = v.pc8; rd1_d = v.rd1; rd2_d = v.rd2;
        a3_m = v.a3m; we_m = v.wem; wd_m = v.wdm;
        a3_w = v.a3w; we_w = v.wew; wd_w = v.wdw;
        stall = v.stl; flush = v.fls;
    endtask

    task automatic push_exp(input logic [31:0] ir, input logic [31:0] pc8,
                            input logic [31:0] na, input logic [31:0] nb, input logic [31:0] rt);
        exp_t e;
        e.ir = ir; e.pc8 = pc8; e.na = na; e.nb = nb; e.rt = rt;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;

        // ir, pc8, rd1, rd2, a3m, wem, wdm, a3w, wew, wdw, stall, flush, exp ir/pc8/numa/numb/rt
        vecs.push_back(mkv(32'h00221821, 32'h3010, 32'd5, 32'd7, 5'd3, 1'b1, 32'hDEAD, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0,
                           32'h00221821, 32'h3010, 32'd5, 32'd7, 32'd7));
        vecs.push_back(mkv(32'h00221821, 32'h3014, 32'd5, 32'd7, 5'd1, 1'b1, 32'd9, 5'd1, 1'b1, 32'd4, 1'b0, 1'b0,
                           32'h00221821, 32'h3014, 32'd9, 32'd7, 32'd7));
        vecs.push_back(mkv(32'h00221821, 32'h3018, 32'd5, 32'd7, 5'd1, 1'b0, 32'd9, 5'd1, 1'b1, 32'd4, 1'b0, 1'b0,
                           32'h00221821, 32'h3018, 32'd4, 32'd7, 32'd7));
        vecs.push_back(mkv(32'h34018000, 32'h301C, 32'h123, 32'h55, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0,
                           32'h34018000, 32'h301C, 32'h0, 32'h00008000, 32'h55));
        vecs.push_back(mkv(32'h8C41FFFC, 32'h3020, 32'h1000, 32'h77, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0,
                           32'h8C41FFFC, 32'h3020, 32'h1000, 32'hFFFFFFFC, 32'h77));
        vecs.push_back(mkv(32'hAC450000, 32'h3024, 32'h2000, 32'h11, 5'd5, 1'b1, 32'hAA, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0,
                           32'hAC450000, 32'h3024, 32'h2000, 32'h0, 32'hAA));
        vecs.push_back(mkv(32'h3C048001, 32'h3028, 32'h9, 32'h8, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0,
                           32'h3C048001, 32'h3028, 32'h0, 32'h00008001, 32'h8));
        vecs.push_back(mkv(32'h1022FFFF, 32'h302C, 32'h3, 32'h4, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0,
                           32'h1022FFFF, 32'h302C, 32'h3, 32'hFFFFFFFF, 32'h4));
        vecs.push_back(mkv(32'h00221821, 32'h3030, 32'd5, 32'd7, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0,
                           32'h0, 32'h3008, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mkv(32'h00221821, 32'h3034, 32'd5, 32'd7, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1,
                           32'h0, 32'h3008, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mkv(32'h8C41FFFC, 32'h3038, 32'd5, 32'd7, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1,
                           32'h0, 32'h3008, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mkv(32'h00001821, 32'h303C, 32'h5, 32'h6, 5'd0, 1'b1, 32'hFFFF, 5'd0, 1'b1, 32'h1234, 1'b0, 1'b0,
                           32'h00001821, 32'h303C, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mkv(32'h00221821, 32'h3040, 32'd5, 32'd7, 5'd9, 1'b1, 32'h1, 5'd2, 1'b1, 32'hBEEF, 1'b0, 1'b0,
                           32'h00221821, 32'h3040, 32'd5, 32'hBEEF, 32'hBEEF));
        vecs.push_back(mkv(32'h00221821, 32'h3044, 32'd5, 32'd7, 5'd2, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 1'b0, 1'b0,
                           32'h00221821, 32'h3044, 32'd5, 32'h11, 32'h11));
        vecs.push_back(mkv(32'h08000C00, 32'h3048, 32'h44, 32'h66, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0,
                           32'h08000C00, 32'h3048, 32'h0, 32'h00000C00, 32'h0));
        vecs.push_back(mkv(32'h00000000, 32'h304C, 32'h44, 32'h66, 5'd0, 1'b1, 32'h5, 5'd0, 1'b1, 32'h6, 1'b0, 1'b0,
                           32'h0, 32'h304C, 32'h0, 32'h0, 32'h0));

        // Reset held low with live inputs: E must stay at reset values.
        reset_n = 1'b0;
        drive(vecs[0]);
        we_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_exp(32'h0, 32'h3008, 32'h0, 32'h0, 32'h0);
        check_outputs("reset");

        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            push_exp(vecs[i].e_ir, vecs[i].e_pc8, vecs[i].e_numa, vecs[i].e_numb, vecs[i].e_rt);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i));
        end

        // Mid-cycle reset: capture lw, then pull reset_n low between edges.
        @(negedge clk);
        drive(vecs[4]);
        push_exp(32'h8C41FFFC, 32'h3020, 32'h1000, 32'hFFFFFFFC, 32'h77);
        @(posedge clk);
        #1;
        check_outputs("pre_async");
        #2;
        reset_n = 1'b0;
        #1;
        push_exp(32'h0, 32'h3008, 32'h0, 32'h0, 32'h0);
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        push_exp(32'h0, 32'h3008, 32'h0, 32'h0, 32'h0);
        check_outputs("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        drive(vecs[5]);
        push_exp(32'hAC450000, 32'h3024, 32'h2000, 32'h0, 32'hAA);
        @(posedge clk);
        #1;
        check_outputs("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
